led_req_arbiter: RTL and testbench

Round-robin arbiter that shares one LED display among several pulse-producing requesters, e.g. the synchronized button/event channels that emit one-cycle `valid` pulses. It latches each pulse as a pending request and grants the display to one requester at a time. The granted requester's one-hot code is held on the LEDs for a fixed number of cycles, and a one-cycle `read` acknowledge goes back to that requester. It sits between the input synchronizer stage and the LED pins.

---
 rtl/led_req_arbiter_if.sv | 33 +++
 rtl/led_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_led_req_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/led_req_arbiter_if.sv
// led_req_arbiter_if: requester/LED bundle for led_req_arbiter.
//   req_valid : one-cycle request pulses from the requesters
//   req_read  : one-cycle acknowledge to the requester being granted
//   led       : one-hot of the granted requester while holding, else 0
//   grant_id  : index of the current or last granted requester
//   busy      : high while a pattern is held on the LEDs
//   done      : pulse on the last hold cycle
//   drop_cnt  : saturating count of requests lost to an already-pending bit
// master = requester/pin side, slave = arbiter.
interface led_req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_read;
  logic [N_REQ-1:0] led;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output req_valid,
    input  req_read, led, grant_id, busy, done, drop_cnt
  );

  modport slave (
    input  req_valid,
    output req_read, led, grant_id, busy, done, drop_cnt
  );
endinterface

// File: rtl/led_req_arbiter.sv
// led_req_arbiter: round-robin arbiter sharing one LED display among N_REQ
// pulse-producing requesters. Each pulse is latched as a pending request; the
// winner's one-hot code is held on the LEDs for HOLD_CYCLES cycles, followed
// by one blank GAP cycle in which the next winner is chosen.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : led_req_arbiter_if.slave (req_valid in; req_read, led, grant_id,
//           busy, done, drop_cnt out -- all registered)

// Per-requester pending bit. A new pulse beats a same-cycle grant clear, and a
// pulse that lands on a still-pending bit is reported as a drop.
module led_req_lane (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic pend,
  output logic drop
);
  always_ff @(posedge clk) begin
    if (!reset) pend <= 1'b0;
    else        pend <= set | (pend & ~clr);
  end

  assign drop = set & pend & ~clr;
endmodule

module led_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              reset,
  led_req_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [IW-1:0]    rr, win, cand;
  logic             found, grant;
  logic [N_REQ-1:0] pend, clr, drop, win_oh;

  logic [N_REQ-1:0] req_read_q, led_q;
  logic [IW-1:0]    grant_id_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] drop_cnt_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign clr[i] = grant && (win == IW'(i));
    led_req_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .set   (bus.req_valid[i]),
      .clr   (clr[i]),
      .pend  (pend[i]),
      .drop  (drop[i])
    );
  end

  // First pending requester at or after rr, wrapping mod N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = rr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && pend[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + IW'(1);
    end
  end

  // IDLE and GAP both arbitrate; HOLD never does.
  assign grant  = found && (state != HOLD);
  assign win_oh = N_REQ'(1) << win;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE, GAP: begin
        if (grant) begin
          state_nx = HOLD;
          cnt_nx   = CW'(HOLD_CYCLES - 1);
        end else begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nx = GAP;
        else           cnt_nx   = cnt - CW'(1);
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rr         <= '0;
      req_read_q <= '0;
      led_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      busy_q <= (state_nx == HOLD);
      done_q <= (state_nx == HOLD) && (cnt_nx == '0);
      if (grant) begin
        rr         <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
        grant_id_q <= win;
        led_q      <= win_oh;
        req_read_q <= win_oh;
      end else begin
        req_read_q <= '0;
        if (state_nx != HOLD) led_q <= '0;
      end
      // Any number of same-cycle drops counts once.
      if (|drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign bus.req_read = req_read_q;
  assign bus.led      = led_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_led_req_arbiter.sv
// Bench for led_req_arbiter: two instances share stimulus, A with defaults
// (HOLD_CYCLES=8, CNT_W=8) and B with HOLD_CYCLES=1, CNT_W=2. Each is compared
// every cycle against an abstract model (pending set, rr pointer, hold cycles
// left), plus directed checks of the scenario timings.
module tb_led_req_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  led_req_arbiter_if #(.N_REQ(4), .CNT_W(8)) ba ();
  led_req_arbiter_if #(.N_REQ(4), .CNT_W(2)) bb ();

  led_req_arbiter #(.N_REQ(4), .HOLD_CYCLES(8), .CNT_W(8)) dut_a (
    .clk (clk), .reset (reset), .bus (ba)
  );
  led_req_arbiter #(.N_REQ(4), .HOLD_CYCLES(1), .CNT_W(2)) dut_b (
    .clk (clk), .reset (reset), .bus (bb)
  );

  typedef struct {
    bit [3:0] pend;
    int       rr;
    int       hold_left;  // HOLD cycles remaining including the current one
    int       gid;
    int       drop;
    int       rd;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, logic [3:0] v, bit rst, int hold, int cmax);
    mdl_t r;
    int   g, i;
    bit   anyd;
    r = m; g = -1; anyd = 0;
    if (rst) begin
      r.pend = '0; r.rr = 0; r.hold_left = 0; r.gid = 0; r.drop = 0; r.rd = 0;
      return r;
    end
    if (m.hold_left == 0 && m.pend != 0)
      for (int k = 0; k < 4; k++) begin
        i = (m.rr + k) % 4;
        if (g < 0 && m.pend[i]) g = i;
      end
    for (int j = 0; j < 4; j++) begin
      if (v[j] && m.pend[j] && j != g) anyd = 1;
      r.pend[j] = v[j] || (m.pend[j] && j != g);
    end
    if (anyd && r.drop < cmax) r.drop++;
    r.rd = 0;
    if (g >= 0) begin
      r.hold_left = hold; r.rr = (g + 1) % 4; r.gid = g; r.rd = 1 << g;
    end else if (m.hold_left > 0) begin
      r.hold_left = m.hold_left - 1;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(string p, mdl_t m, logic [31:0] led, logic [31:0] rd,
                         logic [31:0] gid, logic [31:0] busy, logic [31:0] done,
                         logic [31:0] drop);
    chk({p, ".led"},  led,  m.hold_left > 0 ? (1 << m.gid) : 0);
    chk({p, ".read"}, rd,   m.rd);
    chk({p, ".gid"},  gid,  m.gid);
    chk({p, ".busy"}, busy, m.hold_left > 0 ? 1 : 0);
    chk({p, ".done"}, done, m.hold_left == 1 ? 1 : 0);
    chk({p, ".drop"}, drop, m.drop);
  endtask

  task automatic step(input logic [3:0] v, input bit rst = 0);
    ba.req_valid = v; bb.req_valid = v; reset = ~rst;
    @(posedge clk); #1;
    ba.req_valid = '0; bb.req_valid = '0; reset = 1'b1;
    ma = mstep(ma, v, rst, 8, 255);
    mb = mstep(mb, v, rst, 1, 3);
    chk_dut("A", ma, 32'(ba.led), 32'(ba.req_read), 32'(ba.grant_id),
            32'(ba.busy), 32'(ba.done), 32'(ba.drop_cnt));
    chk_dut("B", mb, 32'(bb.led), 32'(bb.req_read), 32'(bb.grant_id),
            32'(bb.busy), 32'(bb.done), 32'(bb.drop_cnt));
  endtask

  logic [3:0] seen[$];
  int         at[$];

  task automatic collect(int n);
    seen.delete(); at.delete();
    for (int c = 0; c < n; c++) begin
      step(4'b0);
      if (ba.req_read != 0) begin seen.push_back(ba.req_read); at.push_back(c); end
    end
  endtask

  initial begin
    logic [3:0] v;
    reset = 1'b0;
    ba.req_valid = '0; bb.req_valid = '0;
    ma = '{default: 0}; mb = '{default: 0};

    // Reset state
    step(4'b0, 1); step(4'b0, 1);
    chk("rst.led", 32'(ba.led), 0);
    chk("rst.drop", 32'(ba.drop_cnt), 0);
    repeat (3) step(4'b0);

    // Single request: 2-cycle latency, 8-cycle hold, done on last, then GAP
    step(4'b0010);
    chk("single.t1.led", 32'(ba.led), 0);
    step(4'b0);
    chk("single.t2.led", 32'(ba.led), 32'b0010);
    chk("single.t2.read", 32'(ba.req_read), 32'b0010);
    chk("single.gid", 32'(ba.grant_id), 1);
    repeat (6) step(4'b0);
    chk("single.h7.done", 32'(ba.done), 0);
    step(4'b0);
    chk("single.h8.done", 32'(ba.done), 1);
    chk("single.h8.led", 32'(ba.led), 32'b0010);
    step(4'b0);
    chk("single.gap.led", 32'(ba.led), 0);
    chk("single.gap.busy", 32'(ba.busy), 0);
    step(4'b0);

    // Simultaneous requests after reset: 0,1,2,3 spaced 9 cycles
    step(4'b0, 1);
    step(4'b1111);
    collect(40);
    chk("rr.count", seen.size(), 4);
    for (int k = 0; k < seen.size() && k < 4; k++) chk("rr.order", 32'(seen[k]), 1 << k);
    for (int k = 1; k < at.size(); k++) chk("rr.spacing", at[k] - at[k-1], 9);

    // Re-request and drop
    step(4'b0011); step(4'b0);
    chk("drop.h0.read", 32'(ba.req_read), 32'b0001);
    chk("drop.pre", 32'(ba.drop_cnt), 0);
    step(4'b0010);
    chk("drop.one", 32'(ba.drop_cnt), 1);
    step(4'b0001);
    chk("drop.self", 32'(ba.drop_cnt), 1);
    collect(30);
    chk("drop.grants", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("drop.first", 32'(seen[0]), 32'b0010);
      chk("drop.second", 32'(seen[1]), 32'b0001);
    end

    // Set/clear collision: pulse on requester 2 in its own grant cycle
    step(4'b0100); step(4'b0100);
    chk("coll.read", 32'(ba.req_read), 32'b0100);
    chk("coll.nodrop", 32'(ba.drop_cnt), 1);
    collect(25);
    chk("coll.regrant", seen.size(), 1);
    if (seen.size() == 1) chk("coll.id", 32'(seen[0]), 32'b0100);

    // Reset in the 4th HOLD cycle wipes pending requests
    step(4'b0101); step(4'b0);
    repeat (3) step(4'b0);
    chk("mid.h4.busy", 32'(ba.busy), 1);
    step(4'b0, 1);
    chk("mid.led", 32'(ba.led), 0);
    chk("mid.busy", 32'(ba.busy), 0);
    chk("mid.drop", 32'(ba.drop_cnt), 0);
    collect(30);
    chk("mid.nogrant", seen.size(), 0);

    // Saturation: continuous pulses, B's 2-bit counter stops at 3
    repeat (8) step(4'b1111);
    chk("sat.b", 32'(bb.drop_cnt), 3);
    chk("sat.a", 32'(ba.drop_cnt), 7);
    repeat (60) step(4'b0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 4; j++) v[j] = ($urandom_range(0, 5) == 0);
      step(v, $urandom_range(0, 99) == 0);
    end
    repeat (50) step(4'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
